// File: rtl/neural_pkg.sv
// Shared types and Q-format constants for the neuron MAC engine.
package neural_pkg;

  // Default number of fractional bits (Q8.8 with a 16-bit word).
  localparam int FRAC_DEF = 8;

  // Fixed-point 1.0 in the default Q format.
  localparam int ONE = 1 << FRAC_DEF;

  // Activation selector. Code 3 is unused and behaves as identity.
  typedef enum logic [1:0] {
    ACT_ID   = 2'd0,
    ACT_RELU = 2'd1,
    ACT_HSIG = 2'd2
  } act_mode_t;

  // Job sequencing states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_ACT   = 2'd2,
    S_OUT   = 2'd3
  } neuron_state_t;

endpackage

// File: rtl/neuron_mac_activation_unit.sv
// Combinational back end: adds the bias, rescales the accumulator to the
// output Q format, clips to the word range and applies the activation.
module activation_unit
  import neural_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC   = FRAC_DEF,
  parameter int ACC_W  = 40
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic        [DATA_W-1:0] bias_i,
  input  logic        [1:0]        mode_i,
  output logic        [DATA_W-1:0] y_o,
  output logic                     sat_o
);

  // One guard bit above the accumulator so the bias add can never overflow.
  localparam int SUM_W = ACC_W + 1;
  localparam int HW    = DATA_W + 2;

  localparam logic signed [SUM_W-1:0] S_MAX = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] S_MIN = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [HW-1:0]    ONE_H  = HW'(1) << FRAC;
  localparam logic signed [HW-1:0]    HALF_H = HW'(1) << (FRAC - 1);

  logic signed [SUM_W-1:0]  bias_ext;
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  s_full;
  logic signed [DATA_W-1:0] s_clip;
  logic signed [HW-1:0]     s_wide;
  logic signed [HW-1:0]     hsig;

  // Bias alignment, floor rescale, clip and activation select.
  always_comb begin
    bias_ext = {{(SUM_W-DATA_W){bias_i[DATA_W-1]}}, bias_i} <<< FRAC;
    sum      = {acc_i[ACC_W-1], acc_i} + bias_ext;
    s_full   = sum >>> FRAC;

    sat_o  = 1'b0;
    s_clip = s_full[DATA_W-1:0];
    if (s_full > S_MAX) begin
      sat_o  = 1'b1;
      s_clip = S_MAX[DATA_W-1:0];
    end else if (s_full < S_MIN) begin
      sat_o  = 1'b1;
      s_clip = S_MIN[DATA_W-1:0];
    end

    s_wide = {{2{s_clip[DATA_W-1]}}, s_clip};
    hsig   = (s_wide >>> 2) + HALF_H;
    if (hsig < 0) begin
      hsig = '0;
    end else if (hsig > ONE_H) begin
      hsig = ONE_H;
    end

    case (mode_i)
      ACT_RELU: y_o = s_clip[DATA_W-1] ? '0 : s_clip;
      ACT_HSIG: y_o = hsig[DATA_W-1:0];
      default:  y_o = s_clip;
    endcase
  end

endmodule

// File: rtl/neuron_mac.sv
// Fixed-point neuron engine: streams (x, w) pairs into a wide accumulator,
// adds a bias, activates and returns one result over valid/ready.
module neuron_mac
  import neural_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FRAC       = FRAC_DEF,
  parameter int MAX_INPUTS = 64,
  parameter int ACC_W      = 40,
  localparam int N_W       = $clog2(MAX_INPUTS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_W-1:0]    cfg_n_inputs,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y,
  output logic              out_sat,
  output logic              busy
);

  // The accumulator must hold MAX_INPUTS full products without wrapping.
  if (ACC_W < 2*DATA_W + $clog2(MAX_INPUTS) + 1) begin : g_acc_width_check
    $error("neuron_mac: ACC_W too small for DATA_W and MAX_INPUTS");
  end

  neuron_state_t            state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [N_W-1:0]           cnt_q, cnt_d;
  logic [N_W-1:0]           n_q, n_d;
  logic [DATA_W-1:0]        bias_q, bias_d;
  logic [1:0]               mode_q, mode_d;
  logic [DATA_W-1:0]        y_q, y_d;
  logic                     sat_q, sat_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic [N_W-1:0]             cnt_inc;
  logic [N_W-1:0]             n_clamped;
  logic [DATA_W-1:0]          act_y;
  logic                       act_sat;

  activation_unit #(
    .DATA_W (DATA_W),
    .FRAC   (FRAC),
    .ACC_W  (ACC_W)
  ) u_act (
    .acc_i  (acc_q),
    .bias_i (bias_q),
    .mode_i (mode_q),
    .y_o    (act_y),
    .sat_o  (act_sat)
  );

  // Next-state logic for the job sequencer and its datapath registers.
  always_comb begin
    prod      = signed'(in_x) * signed'(in_w);
    prod_ext  = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    cnt_inc   = cnt_q + N_W'(1);
    n_clamped = (cfg_n_inputs > N_W'(MAX_INPUTS)) ? N_W'(MAX_INPUTS) : cfg_n_inputs;

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    bias_d  = bias_q;
    mode_d  = mode_q;
    y_d     = y_q;
    sat_d   = sat_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          n_d     = n_clamped;
          bias_d  = bias;
          mode_d  = cfg_mode;
          state_d = (n_clamped == '0) ? S_ACT : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_inc;
          if (cnt_inc == n_q) begin
            state_d = S_ACT;
          end
        end
      end
      S_ACT: begin
        y_d     = act_y;
        sat_d   = act_sat;
        state_d = S_OUT;
      end
      default: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      bias_q  <= '0;
      mode_q  <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      bias_q  <= bias_d;
      mode_q  <= mode_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_y     = y_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: the driver queues the expected result
// of each job, an independent monitor checks every output handshake.
module tb_neuron_mac;

  localparam int DATA_W = 16;
  localparam int N_W    = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [N_W-1:0]    cfg_n_inputs;
  logic [1:0]        cfg_mode;
  logic [DATA_W-1:0] bias;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] in_w;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_y;
  logic              out_sat;
  logic              busy;

  neuron_mac dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_n_inputs (cfg_n_inputs),
    .cfg_mode     (cfg_mode),
    .bias         (bias),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_w         (in_w),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_y        (out_y),
    .out_sat      (out_sat),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic              sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every output handshake is compared against the scoreboard head.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output actual y=%h sat=%b required none", out_y, out_sat);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (out_y !== e.y || out_sat !== e.sat) begin
          n_err++;
          $display("FAIL result actual y=%h sat=%b required y=%h sat=%b", out_y, out_sat, e.y, e.sat);
        end else begin
          $display("result y=%h sat=%b ok", out_y, out_sat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue start, queue the expected result, then stream n pairs back to back.
  task automatic run_job(input int n, input logic [1:0] mode, input logic [15:0] b,
                         input logic [15:0] xs [4], input logic [15:0] ws [4],
                         input logic [15:0] ey, input logic es, output int t0);
    exp_t e;
    int   k;
    start        = 1'b1;
    cfg_n_inputs = N_W'(n);
    cfg_mode     = mode;
    bias         = b;
    e.y          = ey;
    e.sat        = es;
    exp_q.push_back(e);
    t0 = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_x     = xs[i];
      in_w     = ws[i];
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 50) begin
        tick();
        k++;
      end
      if (k == 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    if (k == 100) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    if (k == 100) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    int t0;
    logic [15:0] z4 [4];
    z4 = '{16'h0, 16'h0, 16'h0, 16'h0};

    reset        = 1'b1;
    start        = 1'b0;
    cfg_n_inputs = '0;
    cfg_mode     = '0;
    bias         = '0;
    in_valid     = 1'b0;
    in_x         = '0;
    in_w         = '0;
    out_ready    = 1'b1;
    tick();
    tick();
    check("reset_state", {in_ready, out_valid, busy, out_sat, out_y}, 32'd0);
    reset = 1'b0;
    tick();

    // Three-term dot product, identity, with latency check.
    run_job(3, 2'd0, 16'h0080, '{16'h0100, 16'h0080, 16'hFFC0, 16'h0},
            '{16'h0200, 16'hFF00, 16'h0400, 16'h0}, 16'h0100, 1'b0, t0);
    wait_valid();
    check("latency_n3", 32'(cyc - t0), 32'd5);
    drain();

    // Same pairs, ReLU with negative bias.
    run_job(3, 2'd1, 16'hFD00, '{16'h0100, 16'h0080, 16'hFFC0, 16'h0},
            '{16'h0200, 16'hFF00, 16'h0400, 16'h0}, 16'h0000, 1'b0, t0);
    drain();

    // Hard sigmoid upper clamp and midpoint.
    run_job(1, 2'd2, 16'h0000, '{16'h0100, 16'h0, 16'h0, 16'h0},
            '{16'h0200, 16'h0, 16'h0, 16'h0}, 16'h0100, 1'b0, t0);
    drain();
    run_job(1, 2'd2, 16'h0000, z4, z4, 16'h0080, 1'b0, t0);
    drain();

    // Positive and negative saturation.
    run_job(2, 2'd0, 16'h0000, '{16'h7FFF, 16'h7FFF, 16'h0, 16'h0},
            '{16'h7FFF, 16'h7FFF, 16'h0, 16'h0}, 16'h7FFF, 1'b1, t0);
    drain();
    run_job(2, 2'd0, 16'h0000, '{16'h8000, 16'h8000, 16'h0, 16'h0},
            '{16'h7FFF, 16'h7FFF, 16'h0, 16'h0}, 16'h8000, 1'b1, t0);
    drain();

    // Mode 3 behaves as identity: -1.5 * 1.0 + 0.25.
    run_job(1, 2'd3, 16'h0040, '{16'hFE80, 16'h0, 16'h0, 16'h0},
            '{16'h0100, 16'h0, 16'h0, 16'h0}, 16'hFEC0, 1'b0, t0);
    drain();

    // n=0: result is the bias, held under back-pressure; start in handshake ignored.
    out_ready = 1'b0;
    run_job(0, 2'd0, 16'h0123, z4, z4, 16'h0123, 1'b0, t0);
    wait_valid();
    check("latency_n0", 32'(cyc - t0), 32'd2);
    for (int i = 0; i < 3; i++) begin
      check("hold", {15'd0, out_valid, out_y}, {15'd0, 1'b1, 16'h0123});
      tick();
    end
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    check("start_in_handshake_busy", 32'(busy), 32'd0);
    tick();

    // Reset mid-job, then a fresh job must not see stale accumulator state.
    start        = 1'b1;
    cfg_n_inputs = N_W'(4);
    cfg_mode     = 2'd0;
    bias         = 16'h0000;
    tick();
    start    = 1'b0;
    in_x     = 16'h0100;
    in_w     = 16'h0300;
    in_valid = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("mid_job_reset", {in_ready, out_valid, busy, out_sat, out_y}, 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    run_job(1, 2'd0, 16'h0000, '{16'h0100, 16'h0, 16'h0, 16'h0},
            '{16'h0100, 16'h0, 16'h0, 16'h0}, 16'h0100, 1'b0, t0);
    drain();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Parametrised fixed-point neuron engine: accumulates a stream of (input, weight) pairs, adds a bias, applies a selectable activation and returns one result through a valid/ready handshake. It succeeds the purely combinational float sigmoid unit between the Nios PIO ports and the datapath. It adds multi-term dot products, activation modes, saturation reporting and flow control, and takes one job at a time from the CPU-side PIO bridge.

## Interface
- `DATA_W`, 16: signed fixed-point width of x, w, bias and y.
- `FRAC`, 8: fractional bits (Q8.8 by default); 1.0 = 0x0100.
- `MAX_INPUTS`, 64: largest number of pairs per job.
- `ACC_W`, 40: accumulator width; elaboration error if ACC_W < 2*DATA_W + $clog2(MAX_INPUTS) + 1.
- `clk`  in  1  system clock (CLOCK_50 domain).
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  job request, honoured only in IDLE.
- `cfg_n_inputs`  in  $clog2(MAX_INPUTS+1)  pair count, sampled on start.
- `cfg_mode`  in  2  activation: 0 identity, 1 ReLU, 2 hard sigmoid, 3 treated as identity; sampled on start.
- `bias`  in  DATA_W  sampled on start.
- `in_valid` in 1, `in_ready` out 1, `in_x` in DATA_W, `in_w` in DATA_W: pair stream.
- `out_valid` out 1, `out_ready` in 1, `out_y` out DATA_W, `out_sat` out 1: result stream.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ACCUM, ACT, OUT.
- IDLE → ACCUM on start when the sampled n ≥ 1. IDLE → ACT on start when n = 0. On start the accumulator clears and bias and mode are latched. An n above MAX_INPUTS is clamped to MAX_INPUTS.
- ACCUM:
  - `in_ready`=1.
  - Each beat with in_valid&&in_ready does acc += sext(in_x*in_w) (full 2*DATA_W product, Q(2·FRAC)) and increments the count.
  - After the n-th beat, go to ACT. in_valid gaps stall with no state change.
- ACT (1 cycle):
  - s = (acc + (sext(bias) << FRAC)) >>> FRAC (arithmetic, floor).
  - Clip s to the signed DATA_W range. out_sat=1 if clipping occurred.
  - Activation on the clipped value: identity; ReLU = max(s,0); hard sigmoid = clamp((s>>>2) + (1<<(FRAC-1)), 0, 1<<FRAC).
  - Register the result into `out_y` and go to OUT.
- OUT: `out_valid`=1 and `out_y`/`out_sat` stable until out_ready. On handshake go to IDLE.
- start is ignored outside IDLE, including in the cycle of the OUT handshake. The next job is accepted the following cycle.
- in_valid outside ACCUM is ignored (`in_ready`=0). Pairs beyond n are never consumed.

## Timing
- Reset (async assert, sync release): state IDLE, acc 0. `in_ready`, `out_valid`, `busy`, `out_sat` are 0. `out_y` is 0x0000.
- Reset mid-job aborts immediately. No partial result is emitted and no accumulator state survives.
- Latency with start at cycle 0 and in_valid held high:
  - ACCUM occupies cycles 1..n.
  - ACT is cycle n+1.
  - `out_valid` rises at cycle n+2.
  - For n=0, `out_valid` rises at cycle 2.
- Throughput: one pair per cycle; one job per n+3 cycles when out_ready is held high.
- The accumulator never wraps, guaranteed by the ACC_W check.

## Structure
- `neural_pkg`: `act_mode_t` enum (ACT_ID, ACT_RELU, ACT_HSIG), `neuron_state_t` enum, the default FRAC constant, and the Q-format helper constant ONE = 1<<FRAC.
- Sub-module `activation_unit`: combinational. Performs clip + mode select and outputs y and sat. It is instantiated once, feeding the ACT-stage register.
- Top level: replaces the `spu` instance. PIO bits drive start/cfg/pairs; result bits return to the CPU.

## Test plan
- n=3, identity, bias 0x0080, pairs (0x0100,0x0200), (0x0080,0xFF00), (0xFFC0,0x0400), continuous valid → `out_y`=0x0100, `out_sat`=0, `out_valid` at cycle 5.
- Same pairs, ReLU, bias 0xFD00 → `out_y`=0x0000, `out_sat`=0.
- Hard sigmoid, n=1, pair (0x0100,0x0200), bias 0 → `out_y`=0x0100. Then pair (0,0) → `out_y`=0x0080.
- n=2, identity, pairs (0x7FFF,0x7FFF)×2, bias 0 → `out_y`=0x7FFF, `out_sat`=1. Negative case with pairs (0x8000,0x7FFF)×2 → `out_y`=0x8000, `out_sat`=1.
- n=0, bias 0x0123, out_ready low 3 cycles → `out_y`=0x0123 held with `out_valid` high for 3 cycles. A start pulse in the handshake cycle is ignored.
- n=4, reset pulsed after 2 pairs → all outputs 0 next edge. A new job with n=1, pair (0x0100,0x0100), bias 0 → `out_y`=0x0100, showing no stale accumulator.
